clkdiv_bank: RTL and testbench

//  Bank of CHANNELS independent mod-N clock dividers with runtime-programmable period and high time.

---
 rtl/clkdiv_bank.sv | 95 +++++++++
 tb/tb_clkdiv_bank.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/clkdiv_bank.sv
// Bank of independent mod-N clock dividers. Each channel's period and high time are set at runtime
// through a shadowed valid/ready config port and take effect at the period wrap.
module clkdiv_bank #(
    parameter  int CHANNELS    = 4,
    parameter  int WIDTH       = 16,
    parameter  int DEFAULT_DIV = 10,
    localparam int CW          = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] enable,
    input  logic                sync,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CW-1:0]       cfg_chan,
    input  logic [WIDTH-1:0]    cfg_period,
    input  logic [WIDTH-1:0]    cfg_high,
    output logic [CHANNELS-1:0] clk_out,
    output logic [CHANNELS-1:0] tick,
    output logic [CHANNELS-1:0] pending
);

    localparam logic [WIDTH-1:0] DEF_PER  = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0] DEF_HIGH = WIDTH'(DEFAULT_DIV / 2);
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
    localparam logic [WIDTH-1:0] TWO      = WIDTH'(2);

    // A channel number outside the bank never matches, so ready stays high and the write is lost.
    always_comb begin
        cfg_ready = 1'b1;
        for (int i = 0; i < CHANNELS; i++) begin
            if (cfg_chan == CW'(i)) begin
                cfg_ready = !pending[i];
            end
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [WIDTH-1:0] cnt_q;
        logic [WIDTH-1:0] cnt_d;
        logic [WIDTH-1:0] per_q;
        logic [WIDTH-1:0] high_q;
        logic [WIDTH-1:0] shPer_q;
        logic [WIDTH-1:0] shHigh_q;
        logic [WIDTH-1:0] effPer;
        logic             pend_q;
        logic             clk_q;
        logic             tick_q;
        logic             accept;
        logic             wrap;
        logic             apply;

        always_comb begin
            effPer = (per_q < TWO) ? TWO : per_q;
            wrap   = enable[i] && (cnt_q >= effPer - ONE);
            apply  = sync || !enable[i] || wrap;
            accept = cfg_valid && (cfg_chan == CW'(i)) && !pend_q;
            cnt_d  = apply ? '0 : cnt_q + ONE;
        end

        // An accept coinciding with an apply copies the old shadow and leaves the new one pending.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                cnt_q    <= '0;
                per_q    <= DEF_PER;
                high_q   <= DEF_HIGH;
                shPer_q  <= DEF_PER;
                shHigh_q <= DEF_HIGH;
                pend_q   <= 1'b0;
                clk_q    <= 1'b0;
                tick_q   <= 1'b0;
            end else begin
                cnt_q  <= cnt_d;
                clk_q  <= enable[i] && (cnt_q < high_q);
                tick_q <= enable[i] && (cnt_q == '0);
                if (apply) begin
                    per_q  <= shPer_q;
                    high_q <= shHigh_q;
                end
                if (accept) begin
                    shPer_q  <= cfg_period;
                    shHigh_q <= cfg_high;
                    pend_q   <= 1'b1;
                end else if (apply) begin
                    pend_q <= 1'b0;
                end
            end
        end

        assign clk_out[i] = clk_q;
        assign tick[i]    = tick_q;
        assign pending[i] = pend_q;
    end

endmodule

// File: tb/tb_clkdiv_bank.sv
// Directed bench for clkdiv_bank: a table of per-cycle vectors plus hand sequences for
// edge-value periods and sync alignment.
module tb_clkdiv_bank;

    localparam int CH  = 3;
    localparam int W   = 8;
    localparam int DEF = 10;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [2:0]   enable;
    logic         sync;
    logic         cfg_valid;
    logic         cfg_ready;
    logic [1:0]   cfg_chan;
    logic [W-1:0] cfg_period;
    logic [W-1:0] cfg_high;
    logic [2:0]   clk_out;
    logic [2:0]   tick;
    logic [2:0]   pending;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic         rstN;
        logic [2:0]   en;
        logic         valid;
        logic [1:0]   chan;
        logic [W-1:0] per;
        logic [W-1:0] high;
        logic         expReady;
        logic [2:0]   expClk;
        logic [2:0]   expTick;
        logic [2:0]   expPend;
        int           tag;
    } vec_t;

    vec_t vecQ[$];

    always #5 clk = ~clk;

    clkdiv_bank #(.CHANNELS(CH), .WIDTH(W), .DEFAULT_DIV(DEF)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .sync      (sync),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_chan  (cfg_chan),
        .cfg_period(cfg_period),
        .cfg_high  (cfg_high),
        .clk_out   (clk_out),
        .tick      (tick),
        .pending   (pending)
    );

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string what, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", what, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        rst_n      = v.rstN;
        enable     = v.en;
        sync       = 1'b0;
        cfg_valid  = v.valid;
        cfg_chan   = v.chan;
        cfg_period = v.per;
        cfg_high   = v.high;
    endtask

    function automatic void addVec(input logic rstN, input logic [2:0] en, input logic valid,
                                   input logic [1:0] chan, input logic [W-1:0] per, input logic [W-1:0] high,
                                   input logic expReady, input logic [2:0] expClk, input logic [2:0] expTick,
                                   input logic [2:0] expPend, input int tag);
        vec_t v;
        v.rstN = rstN; v.en = en; v.valid = valid; v.chan = chan; v.per = per; v.high = high;
        v.expReady = expReady; v.expClk = expClk; v.expTick = expTick; v.expPend = expPend; v.tag = tag;
        vecQ.push_back(v);
    endfunction

    // Loads a channel while the whole bank is idle; the second idle cycle applies the shadow.
    task automatic configure(input int ch, input int d, input int h);
        enable     = 3'b000;
        sync       = 1'b0;
        cfg_valid  = 1'b1;
        cfg_chan   = 2'(ch);
        cfg_period = W'(d);
        cfg_high   = W'(h);
        @(posedge clk); #1;
        cfg_valid = 1'b0;
        @(posedge clk); #1;
        checkOutput($sformatf("cfg ch%0d pending clear", ch), 32'(pending), 32'd0);
    endtask

    task automatic runPattern(input string name, input int ch, input int period, input int highT, input int edges);
        enable     = 3'b000;
        enable[ch] = 1'b1;
        for (int n = 0; n < edges; n++) begin
            @(posedge clk); #1;
            checkOutput($sformatf("%s clk n=%0d", name, n), 32'(clk_out[ch]), 32'((n % period) < highT));
            checkOutput($sformatf("%s tick n=%0d", name, n), 32'(tick[ch]), 32'((n % period) == 0));
        end
        enable = 3'b000;
    endtask

    initial begin
        logic       c;
        logic       t;
        logic       p;
        logic       r;
        logic [2:0] expC;
        logic [2:0] expT;

        rst_n = 1'b0; enable = '0; sync = 1'b0; cfg_valid = 1'b0;
        cfg_chan = '0; cfg_period = '0; cfg_high = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset clk_out", 32'(clk_out), 32'd0);
        checkOutput("reset tick", 32'(tick), 32'd0);
        checkOutput("reset pending", 32'(pending), 32'd0);
        checkOutput("reset cfg_ready", 32'(cfg_ready), 32'd1);

        // Default period 10 on ch0.
        for (int n = 0; n < 20; n++) begin
            addVec(1'b1, 3'b001, 1'b0, 2'd0, 8'd0, 8'd0, 1'b1,
                   {2'b00, (n % 10) < 5}, {2'b00, (n % 10) == 0}, 3'b000, 1);
        end
        // ch1 reprogrammed to D=7 H=3 mid-period; the old period finishes first.
        for (int m = 1; m <= 24; m++) begin
            c = (m <= 5) ? 1'b1 : (m <= 10) ? 1'b0 : (((m - 11) % 7) < 3);
            t = (m == 1) || (m >= 11 && ((m - 11) % 7) == 0);
            p = (m >= 3 && m <= 9);
            r = !(m >= 4 && m <= 10);
            addVec(1'b1, 3'b010, m == 3, 2'd1, 8'd7, 8'd3, r,
                   {1'b0, c, 1'b0}, {1'b0, t, 1'b0}, {1'b0, p, 1'b0}, 2);
        end
        // ch2 disabled mid-period with D=4 H=1 pending, then restarted.
        for (int k = 1; k <= 14; k++) begin
            c = (k <= 4) ? 1'b1 : (k <= 6) ? 1'b0 : (((k - 7) % 4) == 0);
            t = (k == 1) || (k >= 7 && ((k - 7) % 4) == 0);
            p = (k >= 2 && k <= 4);
            r = !(k >= 3 && k <= 5);
            addVec(1'b1, (k == 5 || k == 6) ? 3'b000 : 3'b100, k == 2, 2'd2, 8'd4, 8'd1, r,
                   {c, 2'b00}, {t, 2'b00}, {p, 2'b00}, 5);
        end
        // Reset while a config is pending, then an out-of-range channel write.
        addVec(1'b1, 3'b100, 1'b1, 2'd2, 8'd3, 8'd1, 1'b1, 3'b100, 3'b100, 3'b100, 6);
        addVec(1'b0, 3'b100, 1'b0, 2'd2, 8'd3, 8'd1, 1'b0, 3'b000, 3'b000, 3'b000, 6);
        for (int j = 0; j <= 10; j++) begin
            addVec(1'b1, 3'b100, j == 1, (j == 1) ? 2'd3 : 2'd2, 8'd2, 8'd1, 1'b1,
                   {(j % 10) < 5, 2'b00}, {(j % 10) == 0, 2'b00}, 3'b000, 6);
        end

        foreach (vecQ[i]) begin
            applyStimulus(vecQ[i]);
            #1;
            checkOutput($sformatf("t%0d v%0d cfg_ready", vecQ[i].tag, i), 32'(cfg_ready), 32'(vecQ[i].expReady));
            @(posedge clk); #1;
            checkOutput($sformatf("t%0d v%0d clk_out", vecQ[i].tag, i), 32'(clk_out), 32'(vecQ[i].expClk));
            checkOutput($sformatf("t%0d v%0d tick", vecQ[i].tag, i), 32'(tick), 32'(vecQ[i].expTick));
            checkOutput($sformatf("t%0d v%0d pending", vecQ[i].tag, i), 32'(pending), 32'(vecQ[i].expPend));
        end

        // Edge values of period and high time.
        configure(0, 0, 1);     runPattern("D0", 0, 2, 1, 8);
        configure(0, 1, 1);     runPattern("D1", 0, 2, 1, 8);
        configure(1, 5, 0);     runPattern("H0", 1, 5, 0, 12);
        configure(2, 9, 9);     runPattern("H9D9", 2, 9, 9, 20);
        configure(0, 255, 128); runPattern("Dmax", 0, 255, 128, 520);

        // Sync alignment with a pending config on ch1.
        configure(0, 4, 2);
        configure(1, 6, 3);
        configure(2, 10, 5);
        enable = 3'b111;
        repeat (7) @(posedge clk);
        #1;
        cfg_valid = 1'b1; cfg_chan = 2'd1; cfg_period = 8'd8; cfg_high = 8'd4;
        @(posedge clk); #1;
        cfg_valid = 1'b0;
        checkOutput("sync pre pending", 32'(pending), 32'b010);
        sync = 1'b1;
        @(posedge clk); #1;
        sync = 1'b0;
        checkOutput("sync applies pending", 32'(pending), 32'd0);
        for (int n = 0; n < 18; n++) begin
            @(posedge clk); #1;
            expC = {(n % 10) < 5, (n % 8) < 4, (n % 4) < 2};
            expT = {(n % 10) == 0, (n % 8) == 0, (n % 4) == 0};
            checkOutput($sformatf("sync clk n=%0d", n), 32'(clk_out), 32'(expC));
            checkOutput($sformatf("sync tick n=%0d", n), 32'(tick), 32'(expT));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
